// File: rtl/branch_pkg.sv
// Shared encodings for the execute-stage branch resolver: funct3 codes, FSM states, PC step.
package branch_pkg;

  localparam int unsigned FUNC_W  = 3;
  localparam int unsigned PC_INCR = 4;

  localparam logic [FUNC_W-1:0] BR_EQ  = 3'b000;
  localparam logic [FUNC_W-1:0] BR_NE  = 3'b001;
  localparam logic [FUNC_W-1:0] BR_LT  = 3'b100;
  localparam logic [FUNC_W-1:0] BR_GE  = 3'b101;
  localparam logic [FUNC_W-1:0] BR_LTU = 3'b110;
  localparam logic [FUNC_W-1:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator; signed or unsigned per funct3, undefined codes give not-taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   in0,
  input  logic [XLEN-1:0]   in1,
  input  logic [FUNC_W-1:0] func,
  output logic              out
);

  always_comb begin
    out = 1'b0;
    case (func)
      BR_EQ:   out = (in0 == in1);
      BR_NE:   out = (in0 != in1);
      BR_LT:   out = ($signed(in0) <  $signed(in1));
      BR_GE:   out = ($signed(in0) >= $signed(in1));
      BR_LTU:  out = (in0 <  in1);
      BR_GEU:  out = (in0 >= in1);
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolver: evaluates one branch per handshake, flags mispredicts, holds redirect.
// Optional BRANCH_MISALIGN_EN adds resp_misalign and reports misaligned taken targets instead of redirecting.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IMM_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_func,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [PC_W-1:0]   req_pc,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic              req_pred_taken,
  input  logic              kill,
  output logic              resp_valid,
  output logic              resp_taken,
  output logic              resp_mispredict,
  output logic              flush,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [PC_W-1:0]   redir_pc
`ifdef BRANCH_MISALIGN_EN
  ,
  output logic              resp_misalign
`endif
);

  localparam int unsigned SEXT_W = PC_W - IMM_W;

  state_e state_q, state_d;

  logic [FUNC_W-1:0] func_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [PC_W-1:0]   pc_q;
  logic [IMM_W-1:0]  imm_q;
  logic              pred_q;

  logic              accept;
  logic              cond;
  logic              misalign;
  logic [PC_W-1:0]   target_raw;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   fallthru;

  logic              resp_valid_d;
  logic              resp_taken_d;
  logic              resp_mispredict_d;
  logic              flush_d;
  logic              redir_valid_d;
  logic [PC_W-1:0]   redir_pc_d;
`ifdef BRANCH_MISALIGN_EN
  logic              resp_misalign_d;
`endif

  assign req_ready = (state_q == IDLE) & ~kill;
  assign accept    = req_valid & req_ready;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .in0  (rs1_q),
    .in1  (rs2_q),
    .func (func_q),
    .out  (cond)
  );

  // Target and fall-through wrap modulo 2^PC_W.
  assign target_raw = pc_q + {{SEXT_W{imm_q[IMM_W-1]}}, imm_q};
  assign fallthru   = pc_q + PC_W'(PC_INCR);

`ifdef BRANCH_MISALIGN_EN
  assign target   = target_raw;
  assign misalign = cond & (target_raw[1:0] != 2'b00);
`else
  assign target   = target_raw & ~PC_W'(1);
  assign misalign = 1'b0;
`endif

  // Next state and next output-register values.
  always_comb begin
    state_d           = state_q;
    resp_valid_d      = 1'b0;
    resp_taken_d      = 1'b0;
    resp_mispredict_d = 1'b0;
    flush_d           = 1'b0;
    redir_valid_d     = redir_valid;
    redir_pc_d        = redir_pc;
`ifdef BRANCH_MISALIGN_EN
    resp_misalign_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (!kill) begin
          resp_valid_d      = 1'b1;
          resp_taken_d      = cond;
          resp_mispredict_d = cond ^ pred_q;
          if (misalign) begin
`ifdef BRANCH_MISALIGN_EN
            resp_misalign_d = 1'b1;
`endif
          end else if (cond ^ pred_q) begin
            flush_d       = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = cond ? target : fallthru;
            state_d       = REDIR;
          end
        end
      end
      REDIR: begin
        // kill takes priority; either way the redirect is retired.
        if (kill || redir_ready) begin
          redir_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        redir_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      pred_q <= 1'b0;
    end else if (accept) begin
      func_q <= req_func;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      pc_q   <= req_pc;
      imm_q  <= req_imm;
      pred_q <= req_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_mispredict <= 1'b0;
      flush           <= 1'b0;
      redir_valid     <= 1'b0;
      redir_pc        <= '0;
`ifdef BRANCH_MISALIGN_EN
      resp_misalign   <= 1'b0;
`endif
    end else begin
      resp_valid      <= resp_valid_d;
      resp_taken      <= resp_taken_d;
      resp_mispredict <= resp_mispredict_d;
      flush           <= flush_d;
      redir_valid     <= redir_valid_d;
      redir_pc        <= redir_pc_d;
`ifdef BRANCH_MISALIGN_EN
      resp_misalign   <= resp_misalign_d;
`endif
    end
  end

endmodule
